lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter: DATA_LEN, 32, data/address width in bits; only 32 supported.
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  execute stage presents a load/store
- req_ready  out  1  lsu accepts request this cycle
- req_is_store  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- req_unsigned  in  1  load zero-extends when 1
- req_addr  in  DATA_LEN  byte address
- req_wdata  in  DATA_LEN  store data, LSB-aligned
- resp_valid  out  1  result/completion valid
- resp_ready  in  1  consumer takes response
- resp_rdata  out  DATA_LEN  extended load data; 0 for stores
- resp_err  out  1  misaligned or illegal size
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  DATA_LEN  word-aligned address (bits[1:0]=0)
- mem_wstrb  out  4  byte enables
- mem_wdata  out  DATA_LEN  lane-shifted store data
- mem_gnt  in  1  bus accepts request
- mem_rvalid  in  1  bus completion (read data or write ack)
- mem_rdata  in  DATA_LEN  read word

Function
REQ-003 SHALL implement FSM states IDLE, REQ, WAIT, RESP.
REQ-004 SHALL assert req_ready only in IDLE; handshake = req_valid && req_ready.
REQ-005 SHALL on handshake register is_store, size, unsigned, addr[1:0], word address, shifted wdata, strobes.
REQ-006 SHALL flag error when size=3, half with addr[0]=1, or word with addr[1:0]!=0; errored request goes IDLE->RESP, no bus activity, resp_err=1, resp_rdata=0.
REQ-007 SHALL otherwise go IDLE->REQ; mem_req=1 and mem_addr/mem_we/mem_wstrb/mem_wdata stable throughout REQ.
REQ-008 SHALL go REQ->WAIT on mem_gnt; mem_req=0 in WAIT.
REQ-009 SHALL in WAIT on mem_rvalid capture mem_rdata and go RESP; mem_rvalid outside WAIT ignored.
REQ-010 SHALL accept mem_gnt and mem_rvalid in the same cycle: REQ->RESP directly with data captured.
REQ-011 SHALL hold resp_valid=1 in RESP with stable outputs until resp_ready; then return to IDLE; next request accepted no earlier than the following cycle.
REQ-012 SHALL produce strobes: byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111; wdata replicated to lanes (byte x4, half x2).
REQ-013 SHALL extract load lane by addr[1:0], sign- or zero-extend per req_unsigned; word ignores req_unsigned.
REQ-014 SHALL give minimum latency handshake->resp_valid of 2 cycles (gnt and rvalid in first REQ cycle), error latency 1 cycle.

Reset
REQ-015 SHALL on rst_n=0, asynchronously: state=IDLE, req_ready=1 after release, resp_valid=0, resp_err=0, resp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0.
REQ-016 SHALL abandon any in-flight transaction on reset; late mem_rvalid after reset ignored (IDLE).

Structure
REQ-017 SHALL place size encodings (SZ_B, SZ_H, SZ_W) and FSM state encoding in shared package lsu_pkg.
REQ-018 SHALL place lane extraction/extension and strobe/wdata generation in one combinational sub-module lsu_align.

Verification
REQ-019 SHALL cover: store byte addr=0x8000_0003 wdata=0xAB, gnt immediate -> mem_addr=0x8000_0000, wstrb=4'b1000, wdata=0xABABABAB, resp_err=0.
REQ-020 SHALL cover: load half signed addr=0x8000_0002, mem_rdata=0x8001_1234 -> resp_rdata=0xFFFF_8001; unsigned -> 0x0000_8001.
REQ-021 SHALL cover: load word addr=0x8000_0006 -> resp_err=1 next cycle, mem_req never asserted.
REQ-022 SHALL cover: mem_gnt delayed 3 cycles, mem_rvalid 2 cycles later, resp_ready low 2 cycles -> mem_req held 4 cycles, resp_valid held 3 cycles, data stable.
REQ-023 SHALL cover: rst_n dropped in WAIT, then mem_rvalid=1 -> all outputs 0, no resp_valid, req_ready=1 after release.
REQ-024 SHALL cover: gnt and rvalid same cycle, load byte unsigned addr=1, rdata=0x0000_F500 -> resp_rdata=0x0000_00F5, 2-cycle latency.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared encodings for the load/store unit. It holds the access
//               size codes, the FSM state codes, and the alignment/legality
//               check that the LSU top applies to each incoming request.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Access size encodings. A value of 3 is illegal.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Returns 1 when the access size is illegal, or when the address is not
  // naturally aligned for that size.
  function automatic logic is_bad_access(input logic [1:0] size,
                                         input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = offset[0];
      SZ_W:    bad = |offset;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Purely combinational byte-lane logic for the LSU.
//               Store side: builds the byte strobes and replicates the store
//               data onto the byte lanes.
//               Load side: extracts the addressed lane from the read word and
//               sign-extends or zero-extends it.
// Ports       : st_size/st_offset/st_wdata  -> st_wstrb, st_wdata_lanes
//               ld_size/ld_offset/ld_unsigned/ld_rdata -> ld_data
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic [1:0]          st_size,
  input  logic [1:0]          st_offset,
  input  logic [DATA_LEN-1:0] st_wdata,
  output logic [3:0]          st_wstrb,
  output logic [DATA_LEN-1:0] st_wdata_lanes,
  input  logic [1:0]          ld_size,
  input  logic [1:0]          ld_offset,
  input  logic                ld_unsigned,
  input  logic [DATA_LEN-1:0] ld_rdata,
  output logic [DATA_LEN-1:0] ld_data
);

  logic [DATA_LEN-1:0] w_shifted;

  // Store side. Data is copied to every lane, so the bus slave only has to
  // honour the strobes and never needs to shift anything.
  always_comb begin
    st_wstrb       = 4'b0000;
    st_wdata_lanes = st_wdata;
    case (st_size)
      SZ_B: begin
        st_wstrb       = 4'b0001 << st_offset;
        st_wdata_lanes = {4{st_wdata[7:0]}};
      end
      SZ_H: begin
        st_wstrb       = 4'b0011 << st_offset;
        st_wdata_lanes = {2{st_wdata[15:0]}};
      end
      SZ_W: begin
        st_wstrb       = 4'b1111;
      end
      default: begin
        st_wstrb       = 4'b0000;
      end
    endcase
  end

  // Load side. The addressed lane is moved down to bit 0 before it is
  // extended.
  always_comb begin
    w_shifted = ld_rdata >> {ld_offset, 3'b000};
    ld_data   = ld_rdata;
    case (ld_size)
      SZ_B:    ld_data = {{(DATA_LEN-8){~ld_unsigned & w_shifted[7]}},
                          w_shifted[7:0]};
      SZ_H:    ld_data = {{(DATA_LEN-16){~ld_unsigned & w_shifted[15]}},
                          w_shifted[15:0]};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : Single-outstanding load/store unit. It accepts one request
//               from the execute stage and checks it for legal size and
//               alignment. A legal request goes out as a word-aligned bus
//               transaction. The unit then waits for completion and holds the
//               extended result until the consumer takes it.
// Ports       : clk, rst_n (async, active-low)
//               req_*  - request from the execute stage (valid/ready)
//               resp_* - result to the consumer (valid/ready)
//               mem_*  - word-aligned bus with request/grant and
//                        completion (rvalid) phases
// Revision    : 1.0 - initial release
// ============================================================================
module lsu
  import lsu_pkg::*;
#(
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_is_store,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [DATA_LEN-1:0] req_addr,
  input  logic [DATA_LEN-1:0] req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_LEN-1:0] resp_rdata,
  output logic                resp_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_LEN-1:0] mem_addr,
  output logic [3:0]          mem_wstrb,
  output logic [DATA_LEN-1:0] mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_LEN-1:0] mem_rdata
);

  logic [1:0]          r_state;
  logic                r_is_store;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [1:0]          r_offset;

  logic                w_handshake;
  logic                w_req_err;
  logic [3:0]          w_st_wstrb;
  logic [DATA_LEN-1:0] w_st_wdata;
  logic [DATA_LEN-1:0] w_ld_data;

  assign req_ready   = (r_state == ST_IDLE);
  assign resp_valid  = (r_state == ST_RESP);
  assign mem_req     = (r_state == ST_REQ);
  assign w_handshake = req_valid & req_ready;
  assign w_req_err   = is_bad_access(req_size, req_addr[1:0]);

  // The store path works on the live request so that the bus fields can be
  // registered on the handshake edge. The load path works on the stored
  // request attributes, because read data comes back in a later cycle.
  lsu_align #(
    .DATA_LEN      (DATA_LEN)
  ) u_align (
    .st_size        (req_size),
    .st_offset      (req_addr[1:0]),
    .st_wdata       (req_wdata),
    .st_wstrb       (w_st_wstrb),
    .st_wdata_lanes (w_st_wdata),
    .ld_size        (r_size),
    .ld_offset      (r_offset),
    .ld_unsigned    (r_unsigned),
    .ld_rdata       (mem_rdata),
    .ld_data        (w_ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_is_store <= 1'b0;
      r_size     <= SZ_B;
      r_unsigned <= 1'b0;
      r_offset   <= 2'b00;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= 4'b0000;
      mem_wdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_handshake) begin
            r_is_store <= req_is_store;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_offset   <= req_addr[1:0];
            resp_rdata <= '0;
            if (w_req_err) begin
              // An illegal request reports its error straight away and never
              // touches the bus.
              resp_err <= 1'b1;
              r_state  <= ST_RESP;
            end else begin
              resp_err  <= 1'b0;
              mem_we    <= req_is_store;
              mem_addr  <= {req_addr[DATA_LEN-1:2], 2'b00};
              mem_wstrb <= w_st_wstrb;
              mem_wdata <= w_st_wdata;
              r_state   <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            // The slave may complete in the same cycle it grants.
            if (mem_rvalid) begin
              resp_rdata <= r_is_store ? '0 : w_ld_data;
              r_state    <= ST_RESP;
            end else begin
              r_state    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            resp_rdata <= r_is_store ? '0 : w_ld_data;
            r_state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu
// Description : Directed, self-checking testbench for lsu. Every expected
//               value below is worked out by hand from the bus and
//               extension rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  lsu #(.DATA_LEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only. Call it at a negedge. It presents one request, and it
  // returns at the next negedge with req_valid dropped.
  task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_is_store = st; req_size = sz;
    req_unsigned = uns; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wstrb !== 4'h0) begin errors++; $display("FAIL rst_mem_wstrb: got %b want 0000", mem_wstrb); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
  endtask

  // Store byte to 0x8000_0003: lane 3 only, with the data copied to all lanes.
  task automatic test_store_byte;
    issue(1'b1, 2'd0, 1'b0, 32'h8000_0003, 32'h0000_00AB);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL sb_mem_req: got %b want 1", mem_req); end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL sb_mem_we: got %b want 1", mem_we); end
    checks++; if (mem_addr !== 32'h8000_0000) begin errors++; $display("FAIL sb_mem_addr: got %h want 80000000", mem_addr); end
    checks++; if (mem_wstrb !== 4'b1000) begin errors++; $display("FAIL sb_wstrb: got %b want 1000", mem_wstrb); end
    checks++; if (mem_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata: got %h want ababab ab", mem_wdata); end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL sb_wait_req: got %b want 0", mem_req); end
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL sb_resp_valid: got %b want 1", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL sb_resp_err: got %b want 0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL sb_resp_rdata: got %h want 0", resp_rdata); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL sb_back_idle: valid %b ready %b want 0 1", resp_valid, req_ready); end
  endtask

  // Half load at offset 2 from 0x8001_1234: the lane is 0x8001, tried signed then unsigned.
  task automatic test_load_half;
    logic [31:0] exp_tab [2];
    exp_tab[0] = 32'hFFFF_8001;
    exp_tab[1] = 32'h0000_8001;
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, 2'd1, i[0], 32'h8000_0002, 32'h0);
      checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h8000_0000) begin errors++; $display("FAIL lh_bus[%0d]: we %b addr %h want 0 80000000", i, mem_we, mem_addr); end
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h8001_1234;
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL lh_valid[%0d]: got %b want 1", i, resp_valid); end
      checks++; if (resp_rdata !== exp_tab[i]) begin errors++; $display("FAIL lh_rdata[%0d]: got %h want %h", i, resp_rdata, exp_tab[i]); end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
    end
  endtask

  // Illegal requests: a misaligned word, a misaligned half, and size 3.
  task automatic test_misaligned;
    logic [1:0]  sz_tab   [3];
    logic [31:0] addr_tab [3];
    sz_tab[0] = 2'd2; addr_tab[0] = 32'h8000_0006;
    sz_tab[1] = 2'd1; addr_tab[1] = 32'h8000_0001;
    sz_tab[2] = 2'd3; addr_tab[2] = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, sz_tab[i], 1'b0, addr_tab[i], 32'h0);
      checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin errors++; $display("FAIL err_resp[%0d]: valid %b err %b want 1 1", i, resp_valid, resp_err); end
      checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL err_rdata[%0d]: got %h want 0", i, resp_rdata); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL err_mem_req[%0d]: got %b want 0", i, mem_req); end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      checks++; if (mem_req !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL err_idle[%0d]: req %b ready %b want 0 1", i, mem_req, req_ready); end
    end
  endtask

  // Grant comes after 3 cycles and rvalid 2 cycles after that. The consumer stalls 2 cycles.
  task automatic test_delayed;
    issue(1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0);
    for (int c = 0; c < 4; c++) begin
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0010 || mem_wstrb !== 4'b1111) begin errors++; $display("FAIL dl_req[%0d]: req %b addr %h strb %b want 1 80000010 1111", c, mem_req, mem_addr, mem_wstrb); end
      if (c == 3) mem_gnt = 1'b1;
      @(negedge clk);
    end
    mem_gnt = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++; if (mem_req !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL dl_wait[%0d]: req %b valid %b want 0 0", c, mem_req, resp_valid); end
      if (c == 1) begin mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D; end
      @(negedge clk);
    end
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL dl_resp[%0d]: valid %b rdata %h want 1 cafef00d", c, resp_valid, resp_rdata); end
      if (c == 2) resp_ready = 1'b1;
      @(negedge clk);
    end
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL dl_done: valid %b want 0", resp_valid); end
  endtask

  // Reset arrives while the unit waits for rvalid, and a late rvalid follows it.
  task automatic test_reset_in_wait;
    issue(1'b1, 2'd2, 1'b0, 32'h8000_0020, 32'h5555_AAAA);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wstrb !== 4'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL rw_bus: req %b we %b addr %h strb %b wd %h want all 0", mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata); end
    checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin errors++; $display("FAIL rw_resp: valid %b err %b rdata %h want 0 0 0", resp_valid, resp_err, resp_rdata); end
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || mem_req !== 1'b0) begin errors++; $display("FAIL rw_late: valid %b rdata %h req %b want 0 0 0", resp_valid, resp_rdata, mem_req); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rw_ready: got %b want 1", req_ready); end
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
  endtask

  // A grant and rvalid in the same cycle give the 2-cycle latency. A request
  // held during RESP must wait until IDLE.
  task automatic test_back_to_back;
    issue(1'b0, 2'd0, 1'b1, 32'h0000_0001, 32'h0);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bb_early: valid %b want 0", resp_valid); end
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_F500;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_00F5) begin errors++; $display("FAIL bb_rdata: valid %b rdata %h want 1 000000f5", resp_valid, resp_rdata); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bb_ready_resp: got %b want 0", req_ready); end
    resp_ready = 1'b1;
    req_valid = 1'b1; req_is_store = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 32'h0000_0042; req_wdata = 32'hFFFF_1234;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++; if (mem_req !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bb_not_taken: req %b ready %b want 0 1", mem_req, req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0040 || mem_wstrb !== 4'b1100 || mem_wdata !== 32'h1234_1234) begin errors++; $display("FAIL bb_second: req %b addr %h strb %b wd %h want 1 00000040 1100 12341234", mem_req, mem_addr, mem_wstrb, mem_wdata); end
    mem_gnt = 1'b1; mem_rvalid = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin errors++; $display("FAIL bb_store_resp: valid %b rdata %h err %b want 1 0 0", resp_valid, resp_rdata, resp_err); end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    resp_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_store_byte();
    test_load_half();
    test_misaligned();
    test_delayed();
    test_reset_in_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
